exec_output_rr_arbiter: RTL

Parametrised successor to the execute-stage output selector. It collects results from NUM_UNITS execution units and forwards one result per cycle to the memory stage. Arbitration is fair round-robin, not fixed priority. The result is held in a registered output stage with a valid/ready handshake and a flush. It sits between the execution units and the memory stage and provides backpressure to the units through canGo_o.

---
 rtl/exec_output_rr_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/exec_output_rr_arbiter.sv
// -----------------------------------------------------------------------------
// exec_output_rr_arbiter
//
// Collects results from NUM_UNITS execution units and forwards one result per
// cycle to the memory stage. Units are served in fair round-robin order. The
// selected result is captured in a single registered output stage that uses a
// valid/ready handshake. A flush discards the buffered result.
//
// Ports
//   clk_i              clock; all state updates on the rising edge
//   reset_i            asynchronous active-high reset
//   valid_i            per-unit "result pending"
//   executeVal_i       per-unit result value        [NUM_UNITS][DATA_W]
//   executeCommands_i  per-unit command             [NUM_UNITS][CMD_W]
//   executeTag_i       per-unit ROB tag             [NUM_UNITS][ROBsizeLog]
//   executeFlags_i     per-unit flags               [NUM_UNITS][FLAG_W]
//   canGo_o            one-hot grant; that unit's result is consumed this cycle
//   flush_i            drop the buffered result and block grants this cycle
//   ready_i            memory stage accepts the output this cycle
//   valid_o            output register holds a valid result
//   dataToMem_o        buffered value
//   commandsToMem_o    buffered command
//   tagToMem_o         buffered ROB tag
//   flagsToMem_o       buffered flags
// -----------------------------------------------------------------------------
module exec_output_rr_arbiter #(
  parameter int unsigned NUM_UNITS  = 4,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned CMD_W      = 10,
  parameter int unsigned FLAG_W     = 4,
  parameter int unsigned ROBsize    = 8,
  parameter int unsigned ROBsizeLog = $clog2(ROBsize + 1)
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic [NUM_UNITS-1:0]                  valid_i,
  input  logic [NUM_UNITS-1:0][DATA_W-1:0]      executeVal_i,
  input  logic [NUM_UNITS-1:0][CMD_W-1:0]       executeCommands_i,
  input  logic [NUM_UNITS-1:0][ROBsizeLog-1:0]  executeTag_i,
  input  logic [NUM_UNITS-1:0][FLAG_W-1:0]      executeFlags_i,
  output logic [NUM_UNITS-1:0]                  canGo_o,
  input  logic                                  flush_i,
  input  logic                                  ready_i,
  output logic                                  valid_o,
  output logic [DATA_W-1:0]                     dataToMem_o,
  output logic [CMD_W-1:0]                      commandsToMem_o,
  output logic [ROBsizeLog-1:0]                 tagToMem_o,
  output logic [FLAG_W-1:0]                     flagsToMem_o
);

  localparam int unsigned RR_W = $clog2(NUM_UNITS);

  // The tag width must be derived from the ROB depth; a mismatched override
  // would silently truncate or pad tags, so refuse to elaborate.
  if (ROBsizeLog != $clog2(ROBsize + 1)) begin : g_tag_width_check
    $error("exec_output_rr_arbiter: ROBsizeLog does not match ROBsize");
  end

  if (NUM_UNITS < 2) begin : g_num_units_check
    $error("exec_output_rr_arbiter: NUM_UNITS must be at least 2");
  end

  logic [RR_W-1:0] rr_q;
  logic [RR_W-1:0] rr_d;
  logic [RR_W-1:0] grant_idx;
  logic            grant_found;
  logic            accept;
  logic            grant_en;
  int unsigned     search_idx;

  // The output register can take a new result when empty or being drained.
  assign accept = !valid_o || ready_i;

  // Round-robin search starting at rr_q. NUM_UNITS need not be a power of
  // two, so the wrap is an explicit subtract instead of bit truncation.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    search_idx  = 0;
    for (int unsigned off = 0; off < NUM_UNITS; off++) begin
      search_idx = 32'(rr_q) + off;
      if (search_idx >= NUM_UNITS) begin
        search_idx = search_idx - NUM_UNITS;
      end
      if (!grant_found && valid_i[search_idx]) begin
        grant_found = 1'b1;
        grant_idx   = search_idx[RR_W-1:0];
      end
    end
  end

  // Grants are suppressed while reset is held so no unit believes its result
  // was consumed by a register that is being cleared.
  assign grant_en = accept && !flush_i && grant_found && !reset_i;

  always_comb begin
    canGo_o = '0;
    if (grant_en) begin
      canGo_o = NUM_UNITS'(1) << grant_idx;
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (grant_en) begin
      rr_d = (grant_idx == RR_W'(NUM_UNITS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_o <= 1'b0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
    end else if (grant_en) begin
      valid_o <= 1'b1;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

  // Payload only changes on a grant, so it stays stable under backpressure
  // and keeps the last value once drained.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      dataToMem_o     <= '0;
      commandsToMem_o <= '0;
      tagToMem_o      <= '0;
      flagsToMem_o    <= '0;
    end else if (grant_en) begin
      dataToMem_o     <= executeVal_i[grant_idx];
      commandsToMem_o <= executeCommands_i[grant_idx];
      tagToMem_o      <= executeTag_i[grant_idx];
      flagsToMem_o    <= executeFlags_i[grant_idx];
    end
  end

endmodule
